// File: rtl/ngv_drive_seq.sv
// ngv_drive_seq: two-phase non-overlapping drive sequencer with dead time,
// PLL-lock qualification, double-buffered configuration and sticky fault.
module ngv_drive_seq #(
  parameter int          CNT_W    = 32,
  parameter int unsigned HP_DEF   = 42000000,
  parameter int unsigned DEAD_DEF = 8,
  parameter int          LOCK_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_lock,
  input  logic             en,
  input  logic             fault_in,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_hp,
  input  logic [7:0]       cfg_dead,
  output logic             cfg_ack,
  output logic             out1,
  output logic             out2,
  output logic             running,
  output logic             fault_flag
);

  localparam int               LCW       = $clog2(LOCK_CYC + 1);
  localparam logic [LCW-1:0]   LOCK_LAST = LCW'(LOCK_CYC - 1);
  localparam logic [CNT_W-1:0] HP_INIT   = CNT_W'(HP_DEF);
  localparam logic [7:0]       DEAD_INIT = 8'(DEAD_DEF);

  typedef enum logic [2:0] {
    IDLE, LOCKWAIT, DRV_A, DEAD_AB, DRV_B, DEAD_BA, STOP, FAULT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hp_stg, hp_act;
  logic [7:0]       dead_stg, dead_act;
  logic [CNT_W-1:0] phase_cnt;
  logic [LCW-1:0]   lock_cnt;
  logic [CNT_W-1:0] dead_last, stop_last;
  logic             run_st, timed_st, a_entry;

  // Next-state decode; fault requests outrank every other transition
  always_comb begin
    state_nxt = state;
    dead_last = CNT_W'(dead_act) - 1'b1;
    stop_last = (dead_act == 8'd0) ? '0 : dead_last;
    run_st    = (state == DRV_A) || (state == DEAD_AB) ||
                (state == DRV_B) || (state == DEAD_BA);
    timed_st  = run_st || (state == STOP);
    if (fault_in && state != FAULT) begin
      state_nxt = FAULT;
    end else if (!pll_lock && timed_st) begin
      state_nxt = FAULT;
    end else if (run_st && !en) begin
      state_nxt = STOP;
    end else begin
      case (state)
        IDLE:     if (en) state_nxt = LOCKWAIT;
        LOCKWAIT: begin
          if (!en) state_nxt = IDLE;
          else if (pll_lock && lock_cnt == LOCK_LAST) state_nxt = DRV_A;
        end
        DRV_A:    if (phase_cnt == hp_act) state_nxt = (dead_act == 8'd0) ? DRV_B : DEAD_AB;
        DEAD_AB:  if (phase_cnt == dead_last) state_nxt = DRV_B;
        DRV_B:    if (phase_cnt == hp_act) state_nxt = (dead_act == 8'd0) ? DRV_A : DEAD_BA;
        DEAD_BA:  if (phase_cnt == dead_last) state_nxt = DRV_A;
        STOP:     if (phase_cnt == stop_last) state_nxt = IDLE;
        FAULT:    if (!en && !fault_in) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
    a_entry = (state_nxt == DRV_A) && (state != DRV_A);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Staging registers capture every load pulse and acknowledge it a cycle later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hp_stg   <= HP_INIT;
      dead_stg <= DEAD_INIT;
      cfg_ack  <= 1'b0;
    end else begin
      cfg_ack <= cfg_load;
      if (cfg_load) begin
        hp_stg   <= cfg_hp;
        dead_stg <= cfg_dead;
      end
    end
  end

  // Active timing only follows staging while idle or at the start of a phase-A period
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hp_act   <= HP_INIT;
      dead_act <= DEAD_INIT;
    end else if (state == IDLE || a_entry) begin
      hp_act   <= hp_stg;
      dead_act <= dead_stg;
    end
  end

  // Lock qualifier and phase timer; both restart on any state change so they never wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_cnt  <= '0;
      phase_cnt <= '0;
    end else begin
      if (state == LOCKWAIT && state_nxt == LOCKWAIT && pll_lock) lock_cnt <= lock_cnt + 1'b1;
      else                                                         lock_cnt <= '0;
      if (timed_st && state_nxt == state) phase_cnt <= phase_cnt + 1'b1;
      else                                phase_cnt <= '0;
    end
  end

  // Registered outputs decoded from the next state so they align with the state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out1       <= 1'b0;
      out2       <= 1'b0;
      running    <= 1'b0;
      fault_flag <= 1'b0;
    end else begin
      out1       <= (state_nxt == DRV_A);
      out2       <= (state_nxt == DRV_B);
      running    <= (state_nxt == DRV_A) || (state_nxt == DEAD_AB) ||
                    (state_nxt == DRV_B) || (state_nxt == DEAD_BA);
      fault_flag <= (state_nxt == FAULT);
    end
  end

endmodule
